// File: rtl/clock_mode_ctrl.sv
// Mode controller and count sequencer for the digital clock: key debouncing, the
// NORMAL/SET_HOUR/SET_MIN/SET_SEC machine, counter strobes, blink mask and timeout.
module clock_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_S       = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       key_mode_n,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic       sec_tc,
  input  logic       min_tc,
  output logic       sec_en,
  output logic       min_en,
  output logic       hour_en,
  output logic       count_up,
  output logic [2:0] blink_mask,
  output logic [1:0] mode_state,
  output logic       normal_state
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned ToW  = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ToW-1:0]  ToLimit = ToW'(TIMEOUT_S);

  typedef enum logic [1:0] {
    StNormal  = 2'd0,
    StSetHour = 2'd1,
    StSetMin  = 2'd2,
    StSetSec  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Key path: index 0 = mode, 1 = up, 2 = down
  // ---------------------------------------------------------------------------
  logic [2:0]      key_raw;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      deb_q, deb_d;
  logic [2:0]      press_q, press_d;
  logic [CntW-1:0] cnt_q [3];
  logic [CntW-1:0] cnt_d [3];

  assign key_raw = {key_down_n, key_up_n, key_mode_n};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_d[i]   = deb_q[i];
      press_d[i] = 1'b0;
      cnt_d[i]   = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          deb_d[i]   = sync2_q[i];
          // Only the falling (press) edge is an event; releases just track.
          press_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      deb_q   <= 3'b111;
      press_q <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      press_q <= press_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Mode beats up/down; up together with down cancels both.
  logic ev_mode, ev_up, ev_down, ev_any;

  assign ev_mode = press_q[0];
  assign ev_up   = press_q[1] & ~press_q[2] & ~press_q[0];
  assign ev_down = press_q[2] & ~press_q[1] & ~press_q[0];
  assign ev_any  = |press_q;

  // ---------------------------------------------------------------------------
  // Mode FSM and strobe sequencing
  // ---------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic           phase_q, phase_d;
  logic [ToW-1:0] to_q, to_d;
  logic           sec_en_q, sec_en_d;
  logic           min_en_q, min_en_d;
  logic           hour_en_q, hour_en_d;
  logic           count_up_q, count_up_d;
  logic [2:0]     blink_q, blink_d;
  logic           normal_q, normal_d;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    to_d       = to_q;
    sec_en_d   = 1'b0;
    min_en_d   = 1'b0;
    hour_en_d  = 1'b0;
    count_up_d = count_up_q;

    if (state_q == StNormal) begin
      if (tick_1hz) begin
        sec_en_d   = 1'b1;
        min_en_d   = sec_tc;
        hour_en_d  = sec_tc & min_tc;
        count_up_d = 1'b1;
      end
      if (ev_mode) begin
        state_d = StSetHour;
      end
    end else begin
      if (ev_mode) begin
        case (state_q)
          StSetHour: state_d = StSetMin;
          StSetMin:  state_d = StSetSec;
          default:   state_d = StNormal;
        endcase
      end else if (ev_up || ev_down) begin
        hour_en_d  = (state_q == StSetHour);
        min_en_d   = (state_q == StSetMin);
        sec_en_d   = (state_q == StSetSec);
        count_up_d = ev_up;
      end

      // A key event outranks a tick landing in the same cycle.
      if (ev_any) begin
        to_d    = '0;
        phase_d = 1'b0;
      end else if (tick_1hz) begin
        phase_d = ~phase_q;
        if (TIMEOUT_S != 0) begin
          to_d = to_q + 1'b1;
          if (to_d == ToLimit) begin
            state_d = StNormal;
          end
        end
      end
    end

    if (state_d != state_q) begin
      phase_d = 1'b0;
      to_d    = '0;
    end
  end

  always_comb begin
    blink_d = 3'b000;
    if (phase_d) begin
      case (state_d)
        StSetHour: blink_d = 3'b100;
        StSetMin:  blink_d = 3'b010;
        StSetSec:  blink_d = 3'b001;
        default:   blink_d = 3'b000;
      endcase
    end
    normal_d = (state_d == StNormal);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StNormal;
      phase_q    <= 1'b0;
      to_q       <= '0;
      sec_en_q   <= 1'b0;
      min_en_q   <= 1'b0;
      hour_en_q  <= 1'b0;
      count_up_q <= 1'b1;
      blink_q    <= 3'b000;
      normal_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      to_q       <= to_d;
      sec_en_q   <= sec_en_d;
      min_en_q   <= min_en_d;
      hour_en_q  <= hour_en_d;
      count_up_q <= count_up_d;
      blink_q    <= blink_d;
      normal_q   <= normal_d;
    end
  end

  assign sec_en       = sec_en_q;
  assign min_en       = min_en_q;
  assign hour_en      = hour_en_q;
  assign count_up     = count_up_q;
  assign blink_mask   = blink_q;
  assign mode_state   = state_q;
  assign normal_state = normal_q;

endmodule
